// File: rtl/ifu_fetch_buf.sv
// ifu_fetch_buf: fetch PC generator plus prefetch FIFO feeding decode.
// Define IFU_MISALIGN_CHK_EN to halt fetch on a misaligned redirect target.
module ifu_fetch_buf #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] ifu_pc_o,
  input  logic [DATA_W-1:0] ifu_inst_i,
  input  logic              hold_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              ifu_valid_o,
  input  logic              ifu_ready_i,
  output logic [DATA_W-1:0] ifu_inst_o,
  output logic [ADDR_W-1:0] ifu_inst_pc_o,
  output logic              ifu_misalign_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
  logic [DATA_W-1:0] mem_inst_q [DEPTH];
  logic [ADDR_W-1:0] target;
  logic              halted;
  logic              push;
  logic              pop;

`ifdef IFU_MISALIGN_CHK_EN
  logic mis_q, mis_d;

  assign target = jump_addr_i;

  always_comb begin
    mis_d = mis_q;
    if (jump_en_i)
      mis_d = |jump_addr_i[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end

  assign halted         = mis_q;
  assign ifu_misalign_o = mis_q;
`else
  logic unused_addr_lo;

  assign unused_addr_lo = ^jump_addr_i[1:0];
  assign target         = {jump_addr_i[ADDR_W-1:2], 2'b00};
  assign halted         = 1'b0;
  assign ifu_misalign_o = 1'b0;
`endif

  assign ifu_valid_o = (cnt_q != '0);
  assign ifu_pc_o    = pc_q;

  assign push = !jump_en_i && !hold_i && !halted
             && (cnt_q != FULL);
  assign pop  = ifu_valid_o && ifu_ready_i && !jump_en_i;

  // Redirect flushes by snapping rd onto wr.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    rd_d  = pop  ? rd_q + 1'b1 : rd_q;
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    if (jump_en_i) begin
      pc_d  = target;
      cnt_d = '0;
      rd_d  = wr_q;
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_q]   <= pc_q;
      mem_inst_q[wr_q] <= ifu_inst_i;
    end
  end

  assign ifu_inst_o    = ifu_valid_o ? mem_inst_q[rd_q] : '0;
  assign ifu_inst_pc_o = ifu_valid_o ? mem_pc_q[rd_q]   : '0;

endmodule
